multicycle_controller: RTL and testbench

Multicycle control FSM that sequences the shared MIPS-subset datapath: register file, ALU, sign extender, PC, and a single memory port. It replaces single-cycle decoding with per-phase control: fetch, decode, execute, memory, and writeback, one phase per clock. Memory phases wait on a ready handshake, so the datapath can sit behind slow memory. A bounded wait counter halts the core on a memory fault.

---
 rtl/multicycle_controller_if.sv | 36 +++
 rtl/multicycle_controller.sv | 238 +++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the shared datapath.
// The controller is the master: it consumes IR fields and status and drives
// every datapath enable and mux select.
interface multicycle_controller_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       aluZero;
    logic       memReady;
    logic       pcWrEn;
    logic [1:0] pcSrc;
    logic       irWrEn;
    logic       iorD;
    logic       memRdEn;
    logic       memWrEn;
    logic       regWrEn;
    logic [1:0] regDst;
    logic [1:0] writebackSrc;
    logic       aluSrcB;
    logic       extSel;
    logic [2:0] aluCommand;
    logic       instrDone;
    logic       halted;
    logic [1:0] fault;

    modport master (
        input  opcode, funct, aluZero, memReady,
        output pcWrEn, pcSrc, irWrEn, iorD, memRdEn, memWrEn, regWrEn, regDst,
               writebackSrc, aluSrcB, extSel, aluCommand, instrDone, halted, fault
    );

    modport slave (
        output opcode, funct, aluZero, memReady,
        input  pcWrEn, pcSrc, irWrEn, iorD, memRdEn, memWrEn, regWrEn, regDst,
               writebackSrc, aluSrcB, extSel, aluCommand, instrDone, halted, fault
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle control FSM for the MIPS-subset datapath. One phase per clock;
// memory phases wait on memReady with a bounded wait counter that halts the
// core with a timeout fault.
module multicycle_controller #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);
    localparam logic [3:0] StFetch   = 4'd0;
    localparam logic [3:0] StDecode  = 4'd1;
    localparam logic [3:0] StExecR   = 4'd2;
    localparam logic [3:0] StWbR     = 4'd3;
    localparam logic [3:0] StExecI   = 4'd4;
    localparam logic [3:0] StWbI     = 4'd5;
    localparam logic [3:0] StMemAddr = 4'd6;
    localparam logic [3:0] StMemRd   = 4'd7;
    localparam logic [3:0] StWbMem   = 4'd8;
    localparam logic [3:0] StMemWr   = 4'd9;
    localparam logic [3:0] StBranch  = 4'd10;
    localparam logic [3:0] StJump    = 4'd11;
    localparam logic [3:0] StJal     = 4'd12;
    localparam logic [3:0] StJr      = 4'd13;
    localparam logic [3:0] StHalt    = 4'd14;

    localparam logic [5:0] OpRType = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpXori  = 6'h0E;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnJr  = 6'h08;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnSlt = 6'h2A;

    localparam logic [2:0] AluAdd = 3'd0;
    localparam logic [2:0] AluSub = 3'd1;
    localparam logic [2:0] AluXor = 3'd2;
    localparam logic [2:0] AluSlt = 3'd3;

    localparam logic [1:0] FaultNone    = 2'd0;
    localparam logic [1:0] FaultIllegal = 2'd1;
    localparam logic [1:0] FaultTimeout = 2'd2;

    // The cycle in which waitQ equals this value is the TIMEOUT-th wait cycle.
    localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

    logic [3:0] stateQ, stateD;
    logic [1:0] faultQ, faultD;
    logic [7:0] waitQ, waitD;
    logic       memState;
    logic       timedOut;
    logic [2:0] rCmd;

    // Memory-waiting states and the timeout condition shared by all of them.
    always_comb begin
        memState = (stateQ == StFetch) || (stateQ == StMemRd) || (stateQ == StMemWr);
        timedOut = memState && !bus.memReady && (waitQ == WaitLast);
    end

    // ALU command for R-type instructions, decoded from funct.
    always_comb begin
        case (bus.funct)
            FnSub:   rCmd = AluSub;
            FnSlt:   rCmd = AluSlt;
            default: rCmd = AluAdd;
        endcase
    end

    // Next-state, fault and wait-counter logic.
    always_comb begin
        stateD = stateQ;
        faultD = faultQ;
        waitD  = 8'd0;
        case (stateQ)
            StFetch:   if (bus.memReady) stateD = StDecode;
            StDecode: begin
                case (bus.opcode)
                    OpRType: begin
                        if (bus.funct == FnAdd || bus.funct == FnSub || bus.funct == FnSlt) begin
                            stateD = StExecR;
                        end else if (bus.funct == FnJr) begin
                            stateD = StJr;
                        end else begin
                            stateD = StHalt;
                            faultD = FaultIllegal;
                        end
                    end
                    OpLw, OpSw: stateD = StMemAddr;
                    OpXori:     stateD = StExecI;
                    OpBne:      stateD = StBranch;
                    OpJ:        stateD = StJump;
                    OpJal:      stateD = StJal;
                    default: begin
                        stateD = StHalt;
                        faultD = FaultIllegal;
                    end
                endcase
            end
            StExecR:   stateD = StWbR;
            StWbR:     stateD = StFetch;
            StExecI:   stateD = StWbI;
            StWbI:     stateD = StFetch;
            StMemAddr: stateD = (bus.opcode == OpLw) ? StMemRd : StMemWr;
            StMemRd:   if (bus.memReady) stateD = StWbMem;
            StWbMem:   stateD = StFetch;
            StMemWr:   if (bus.memReady) stateD = StFetch;
            StBranch:  stateD = StFetch;
            StJump:    stateD = StFetch;
            StJal:     stateD = StFetch;
            StJr:      stateD = StFetch;
            StHalt:    stateD = StHalt;
            default:   stateD = StFetch;
        endcase
        // Any cycle leaving a memory state or arriving fresh starts from zero.
        if (memState && !bus.memReady) begin
            if (timedOut) begin
                stateD = StHalt;
                faultD = FaultTimeout;
            end else begin
                waitD = waitQ + 8'd1;
            end
        end
    end

    // State, fault and wait-counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= StFetch;
            faultQ <= FaultNone;
            waitQ  <= 8'd0;
        end else begin
            stateQ <= stateD;
            faultQ <= faultD;
            waitQ  <= waitD;
        end
    end

    // Datapath controls: Moore per state, with the few memReady/aluZero Mealy terms.
    always_comb begin
        bus.pcWrEn       = 1'b0;
        bus.pcSrc        = 2'd0;
        bus.irWrEn       = 1'b0;
        bus.iorD         = 1'b0;
        bus.memRdEn      = 1'b0;
        bus.memWrEn      = 1'b0;
        bus.regWrEn      = 1'b0;
        bus.regDst       = 2'd0;
        bus.writebackSrc = 2'd0;
        bus.aluSrcB      = 1'b0;
        bus.extSel       = 1'b1;
        bus.aluCommand   = AluAdd;
        bus.instrDone    = 1'b0;
        bus.halted       = 1'b0;
        bus.fault        = faultQ;
        if (!reset) begin
            case (stateQ)
                StFetch: begin
                    bus.memRdEn = !timedOut;
                    if (bus.memReady) begin
                        bus.irWrEn = 1'b1;
                        bus.pcWrEn = 1'b1;
                    end
                end
                StDecode: ;
                StExecR: bus.aluCommand = rCmd;
                StWbR: begin
                    bus.aluCommand = rCmd;
                    bus.regWrEn    = 1'b1;
                    bus.instrDone  = 1'b1;
                end
                StExecI: begin
                    bus.aluSrcB    = 1'b1;
                    bus.extSel     = 1'b0;
                    bus.aluCommand = AluXor;
                end
                StWbI: begin
                    bus.aluSrcB    = 1'b1;
                    bus.extSel     = 1'b0;
                    bus.aluCommand = AluXor;
                    bus.regWrEn    = 1'b1;
                    bus.regDst     = 2'd1;
                    bus.instrDone  = 1'b1;
                end
                StMemAddr: bus.aluSrcB = 1'b1;
                StMemRd: begin
                    bus.aluSrcB = 1'b1;
                    bus.iorD    = 1'b1;
                    bus.memRdEn = !timedOut;
                end
                StWbMem: begin
                    bus.aluSrcB      = 1'b1;
                    bus.iorD         = 1'b1;
                    bus.regWrEn      = 1'b1;
                    bus.regDst       = 2'd1;
                    bus.writebackSrc = 2'd1;
                    bus.instrDone    = 1'b1;
                end
                StMemWr: begin
                    bus.aluSrcB   = 1'b1;
                    bus.iorD      = 1'b1;
                    bus.memWrEn   = !timedOut;
                    bus.instrDone = bus.memReady;
                end
                StBranch: begin
                    bus.aluCommand = AluSub;
                    bus.pcSrc      = 2'd3;
                    bus.pcWrEn     = !bus.aluZero;
                    bus.instrDone  = 1'b1;
                end
                StJump: begin
                    bus.pcSrc     = 2'd2;
                    bus.pcWrEn    = 1'b1;
                    bus.instrDone = 1'b1;
                end
                StJal: begin
                    bus.pcSrc        = 2'd2;
                    bus.pcWrEn       = 1'b1;
                    bus.regWrEn      = 1'b1;
                    bus.regDst       = 2'd2;
                    bus.writebackSrc = 2'd2;
                    bus.instrDone    = 1'b1;
                end
                StJr: begin
                    bus.pcSrc     = 2'd1;
                    bus.pcWrEn    = 1'b1;
                    bus.instrDone = 1'b1;
                end
                StHalt: bus.halted = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Each instruction is expanded
// into its expected per-cycle control pattern from the instruction class and
// the chosen memory wait lengths, then compared cycle by cycle.
module tb_multicycle_controller;
    localparam int unsigned TO = 4;

    typedef struct packed {
        logic       pcWrEn;
        logic [1:0] pcSrc;
        logic       irWrEn;
        logic       iorD;
        logic       memRdEn;
        logic       memWrEn;
        logic       regWrEn;
        logic [1:0] regDst;
        logic [1:0] wbSrc;
        logic       aluSrcB;
        logic       extSel;
        logic [2:0] aluCmd;
        logic       instrDone;
        logic       halted;
        logic [1:0] fault;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset;
    int         testCnt = 0;
    int         failCnt = 0;
    logic [1:0] modelFault = 2'd0;
    logic [11:0] legal [0:9];

    multicycle_controller_if bus ();

    multicycle_controller #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic ctl_t idle();
        ctl_t c;
        c = '0;
        c.extSel = 1'b1;
        return c;
    endfunction

    function automatic ctl_t observe();
        ctl_t c;
        c.pcWrEn    = bus.pcWrEn;
        c.pcSrc     = bus.pcSrc;
        c.irWrEn    = bus.irWrEn;
        c.iorD      = bus.iorD;
        c.memRdEn   = bus.memRdEn;
        c.memWrEn   = bus.memWrEn;
        c.regWrEn   = bus.regWrEn;
        c.regDst    = bus.regDst;
        c.wbSrc     = bus.writebackSrc;
        c.aluSrcB   = bus.aluSrcB;
        c.extSel    = bus.extSel;
        c.aluCmd    = bus.aluCommand;
        c.instrDone = bus.instrDone;
        c.halted    = bus.halted;
        c.fault     = bus.fault;
        return c;
    endfunction

    task automatic check(input ctl_t obs, input ctl_t exp, input string tag);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, compare at the falling edge, advance.
    task automatic cyc(input ctl_t exp, input logic rdy, input logic z, input string tag);
        bus.memReady = rdy;
        bus.aluZero  = z;
        @(negedge clk);
        check(observe(), exp, tag);
        @(posedge clk);
        #1;
    endtask

    // Reset cycle: only the enables, instrDone and halted are defined here.
    task automatic resetCycle(input logic rdy, input string tag);
        ctl_t o;
        reset = 1'b1;
        bus.memReady = rdy;
        bus.aluZero  = rb();
        @(negedge clk);
        o = observe();
        o.pcSrc  = 2'd0;
        o.regDst = 2'd0;
        o.wbSrc  = 2'd0;
        o.aluSrcB = 1'b0;
        o.extSel = 1'b1;
        o.aluCmd = 3'd0;
        o.fault  = 2'd0;
        check(o, idle(), tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelFault = 2'd0;
    endtask

    task automatic haltCycles(input int n, input string tag);
        ctl_t e;
        for (int i = 0; i < n; i++) begin
            e = idle();
            e.halted = 1'b1;
            e.fault  = modelFault;
            bus.opcode = 6'($urandom);
            cyc(e, rb(), rb(), tag);
        end
    endtask

    // A memory phase: w not-ready cycles then a ready cycle, or a timeout.
    task automatic waitPhase(input ctl_t req, input ctl_t done, input int w, input string tag,
                             output bit ok);
        ctl_t drop;
        ok = 1'b1;
        for (int i = 0; i < w; i++) begin
            if (i == int'(TO) - 1) begin
                drop = req;
                drop.memRdEn = 1'b0;
                drop.memWrEn = 1'b0;
                cyc(drop, 1'b0, rb(), {tag, "-timeout"});
                modelFault = 2'd2;
                ok = 1'b0;
                return;
            end
            cyc(req, 1'b0, rb(), {tag, "-wait"});
        end
        cyc(done, 1'b1, rb(), {tag, "-ready"});
    endtask

    task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int wf, input int wm, input string tag);
        ctl_t e, req, done;
        bit ok;
        bus.opcode = op;
        bus.funct  = fn;
        req = idle();
        req.memRdEn = 1'b1;
        done = req;
        done.irWrEn = 1'b1;
        done.pcWrEn = 1'b1;
        waitPhase(req, done, wf, {tag, "/fetch"}, ok);
        if (!ok) begin
            haltCycles(2, {tag, "/halt"});
            return;
        end
        cyc(idle(), rb(), rb(), {tag, "/decode"});
        e = idle();
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A)) begin
            e.aluCmd = (fn == 6'h20) ? 3'd0 : (fn == 6'h22) ? 3'd1 : 3'd3;
            cyc(e, rb(), rb(), {tag, "/execR"});
            e.regWrEn = 1'b1;
            e.instrDone = 1'b1;
            cyc(e, rb(), rb(), {tag, "/wbR"});
        end else if (op == 6'h00 && fn == 6'h08) begin
            e.pcSrc = 2'd1;
            e.pcWrEn = 1'b1;
            e.instrDone = 1'b1;
            cyc(e, rb(), rb(), {tag, "/jr"});
        end else if (op == 6'h23 || op == 6'h2B) begin
            e.aluSrcB = 1'b1;
            cyc(e, rb(), rb(), {tag, "/addr"});
            req = e;
            req.iorD = 1'b1;
            if (op == 6'h23) begin
                req.memRdEn = 1'b1;
                waitPhase(req, req, wm, {tag, "/memRd"}, ok);
                if (ok) begin
                    e = req;
                    e.memRdEn = 1'b0;
                    e.regWrEn = 1'b1;
                    e.regDst = 2'd1;
                    e.wbSrc = 2'd1;
                    e.instrDone = 1'b1;
                    cyc(e, rb(), rb(), {tag, "/wbMem"});
                end
            end else begin
                req.memWrEn = 1'b1;
                done = req;
                done.instrDone = 1'b1;
                waitPhase(req, done, wm, {tag, "/memWr"}, ok);
            end
            if (!ok) haltCycles(2, {tag, "/halt"});
        end else if (op == 6'h0E) begin
            e.aluSrcB = 1'b1;
            e.extSel = 1'b0;
            e.aluCmd = 3'd2;
            cyc(e, rb(), rb(), {tag, "/execI"});
            e.regWrEn = 1'b1;
            e.regDst = 2'd1;
            e.instrDone = 1'b1;
            cyc(e, rb(), rb(), {tag, "/wbI"});
        end else if (op == 6'h05) begin
            e.aluCmd = 3'd1;
            e.pcSrc = 2'd3;
            e.pcWrEn = !z;
            e.instrDone = 1'b1;
            cyc(e, rb(), z, {tag, "/branch"});
        end else if (op == 6'h02 || op == 6'h03) begin
            e.pcSrc = 2'd2;
            e.pcWrEn = 1'b1;
            e.instrDone = 1'b1;
            if (op == 6'h03) begin
                e.regWrEn = 1'b1;
                e.regDst = 2'd2;
                e.wbSrc = 2'd2;
            end
            cyc(e, rb(), rb(), {tag, "/jump"});
        end else begin
            modelFault = 2'd1;
            haltCycles(2, {tag, "/halt"});
        end
    endtask

    initial begin
        int idx;
        ctl_t e;
        legal = '{{6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h2A}, {6'h00, 6'h08},
                  {6'h23, 6'h00}, {6'h2B, 6'h00}, {6'h0E, 6'h00}, {6'h05, 6'h00},
                  {6'h02, 6'h00}, {6'h03, 6'h00}};
        reset = 1'b1;
        bus.opcode = 6'h00;
        bus.funct = 6'h00;
        bus.aluZero = 1'b0;
        bus.memReady = 1'b0;
        @(posedge clk);
        #1;
        resetCycle(1'b0, "reset0");
        resetCycle(1'b1, "reset1");

        // Directed instructions.
        runInstr(6'h00, 6'h20, 1'b0, 0, 0, "add");
        runInstr(6'h23, 6'h11, 1'b0, 0, 3, "lw-wait3");
        runInstr(6'h05, 6'h00, 1'b1, 0, 0, "bne-taken0");
        runInstr(6'h05, 6'h00, 1'b0, 0, 0, "bne-taken1");
        runInstr(6'h03, 6'h00, 1'b0, 0, 0, "jal");
        runInstr(6'h2B, 6'h00, 1'b0, 1, 2, "sw");
        runInstr(6'h0E, 6'h3F, 1'b0, 2, 0, "xori");
        runInstr(6'h02, 6'h00, 1'b0, 0, 0, "j");
        runInstr(6'h00, 6'h08, 1'b0, 0, 0, "jr");
        runInstr(6'h00, 6'h22, 1'b0, 3, 0, "sub-fetch3");
        runInstr(6'h00, 6'h2A, 1'b0, 0, 0, "slt");

        // Randomized legal instruction stream, waits below the timeout.
        for (int n = 0; n < 60; n++) begin
            idx = int'($urandom_range(0, 9));
            runInstr(legal[idx][11:6], (legal[idx][11:6] == 6'h00) ? legal[idx][5:0]
                     : 6'($urandom), rb(), int'($urandom_range(0, TO - 1)),
                     int'($urandom_range(0, TO - 1)), "rand");
        end

        // Fetch timeout, then reset while halted.
        runInstr(6'h00, 6'h20, 1'b0, 6, 0, "fetch-timeout");
        resetCycle(1'b1, "reset-in-halt");
        runInstr(6'h00, 6'h20, 1'b0, 0, 0, "add-after-halt");

        // Illegal opcode and illegal R-type funct.
        runInstr(6'h3F, 6'h00, 1'b0, 0, 0, "illegal-op");
        resetCycle(1'b0, "reset-illegal-op");
        runInstr(6'h00, 6'h21, 1'b0, 0, 0, "illegal-funct");
        resetCycle(1'b1, "reset-illegal-funct");

        // Load timeout in the data phase.
        runInstr(6'h23, 6'h00, 1'b0, 0, 9, "lw-timeout");
        resetCycle(1'b0, "reset-lw-timeout");

        // Reset in the middle of a store's memory phase.
        bus.opcode = 6'h2B;
        bus.funct = 6'h00;
        e = idle();
        e.memRdEn = 1'b1;
        e.irWrEn = 1'b1;
        e.pcWrEn = 1'b1;
        cyc(e, 1'b1, 1'b0, "swrst/fetch");
        cyc(idle(), 1'b0, 1'b0, "swrst/decode");
        e = idle();
        e.aluSrcB = 1'b1;
        cyc(e, 1'b1, 1'b0, "swrst/addr");
        e.iorD = 1'b1;
        e.memWrEn = 1'b1;
        cyc(e, 1'b0, 1'b0, "swrst/memWr-wait");
        resetCycle(1'b1, "swrst/reset");
        runInstr(6'h0E, 6'h00, 1'b0, 1, 0, "xori-after-rst");

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end
endmodule
